// File: rtl/mcu_spi_pkg.sv
// Shared state type and framing constants for the cartridge MCU SPI physical layer.
`timescale 1ns/1ps
package mcu_spi_pkg;
  localparam int BYTE_CNT_W    = 8;
  localparam int BITS_PER_BYTE = 8;
  localparam int BIT_CNT_W     = $clog2(BITS_PER_BYTE);

  typedef enum logic [1:0] {
    st_Idle,
    st_Shift,
    st_Stretch,
    st_TimedOut
  } PhyState;
endpackage

// File: rtl/sync_falling_edge.sv
// Synchroniser plus registered falling-edge detector; the pulse lands SYNC_STAGES+1 clocks after the fall.
// Resets to "line high" so release of reset never fabricates an edge; no backpressure.
`timescale 1ns/1ps
module sync_falling_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic SClk,
  input  logic nReset,
  input  logic async_in,
  output logic fall_pulse
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) begin
      sync_q     <= '1;
      hist_q     <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q     <= sync_q[SYNC_STAGES-1];
      fall_pulse <= hist_q & ~sync_q[SYNC_STAGES-1];
    end
  end
endmodule

// File: rtl/mcu_spi_phy.sv
// SPI PHY: gated mode-0 clock, MCUReady edge pulse (SYNC_STAGES+1 clocks), byte count and sticky status; no backpressure.
// MCU_SPI_STRETCH_WATCHDOG_EN adds a stretch watchdog that sets Timeout and emits one synthetic ready pulse.
`timescale 1ns/1ps
module mcu_spi_phy
  import mcu_spi_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TIMEOUT_W      = 17
) (
  input  logic                  SClk,
  input  logic                  nReset,
  input  logic                  MCUReady,
  input  logic                  nMCUSel,
  input  logic                  SPIClkRunning,
  input  logic                  SPIClkStretch,
  input  logic                  ClearStatus,
  output logic                  SPIClk,
  output logic                  MCUReadyFallingEdge,
  output logic [BYTE_CNT_W-1:0] ByteCount,
  output logic                  FrameError,
  output logic                  Timeout
);
  localparam logic [BIT_CNT_W-1:0]  BIT_LAST = BIT_CNT_W'(BITS_PER_BYTE - 1);
  localparam logic [BYTE_CNT_W-1:0] BYTE_MAX = '1;
  localparam logic [TIMEOUT_W-1:0]  WD_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  PhyState              state_q, state_d;
  logic                 shift, clk_en_q, real_edge, wd_expire;
  logic                 nsel_q, stretch_q, sel_fall, sel_rise, stretch_rise, frame_err_set;
  logic [BIT_CNT_W-1:0] bit_cnt_q;

  assign shift = SPIClkRunning & ~SPIClkStretch & ~nMCUSel;

  // Enable moves while SClk falls, so SPIClk is high only in the low half of SClk.
  always_ff @(negedge SClk or negedge nReset) begin
    if (!nReset) clk_en_q <= 1'b0;
    else         clk_en_q <= shift;
  end
  assign SPIClk = clk_en_q & ~SClk;

  sync_falling_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rdy_sync (
    .SClk      (SClk),
    .nReset    (nReset),
    .async_in  (MCUReady),
    .fall_pulse(real_edge)
  );

  assign sel_fall      = nsel_q & ~nMCUSel;
  assign sel_rise      = ~nsel_q & nMCUSel;
  assign stretch_rise  = ~stretch_q & SPIClkStretch;
  assign frame_err_set = (sel_rise | stretch_rise) & (bit_cnt_q != '0);

  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) begin
      nsel_q     <= 1'b1;
      stretch_q  <= 1'b0;
      bit_cnt_q  <= '0;
      ByteCount  <= '0;
      FrameError <= 1'b0;
      state_q    <= st_Idle;
    end else begin
      nsel_q    <= nMCUSel;
      stretch_q <= SPIClkStretch;
      state_q   <= state_d;
      if (sel_fall) begin
        bit_cnt_q <= '0;
        ByteCount <= '0;
      end else if (shift) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST && ByteCount != BYTE_MAX) ByteCount <= ByteCount + 1'b1;
      end
      if (frame_err_set)    FrameError <= 1'b1;
      else if (ClearStatus) FrameError <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      st_Idle:     if (!nMCUSel && SPIClkRunning) state_d = st_Shift;
      st_Shift:    if (SPIClkStretch) state_d = st_Stretch;
      st_Stretch:  if (!SPIClkStretch) state_d = st_Shift;
                   else if (wd_expire) state_d = st_TimedOut;
      st_TimedOut: if (!SPIClkStretch) state_d = st_Shift;
      default:     state_d = st_Idle;
    endcase
    if (nMCUSel) state_d = st_Idle;
  end

`ifdef MCU_SPI_STRETCH_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_cnt_q;
  logic                 synth_edge_q;

  // A real ack arriving in the expiry cycle suppresses the synthetic pulse.
  assign wd_expire = (state_q == st_Stretch) && SPIClkStretch && !nMCUSel &&
                     !real_edge && (wd_cnt_q == WD_LAST);

  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) begin
      wd_cnt_q     <= '0;
      synth_edge_q <= 1'b0;
      Timeout      <= 1'b0;
    end else begin
      if (state_q == st_Stretch && state_d == st_Stretch && !real_edge)
        wd_cnt_q <= wd_cnt_q + 1'b1;
      else
        wd_cnt_q <= '0;
      synth_edge_q <= wd_expire;
      if (wd_expire)        Timeout <= 1'b1;
      else if (ClearStatus) Timeout <= 1'b0;
    end
  end

  assign MCUReadyFallingEdge = real_edge | synth_edge_q;
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg       = ^WD_LAST;
  assign wd_expire           = 1'b0;
  assign Timeout             = 1'b0;
  assign MCUReadyFallingEdge = real_edge;
`endif
endmodule

// File: tb/tb_mcu_spi_phy.sv
// Scoreboard bench for mcu_spi_phy: frame-level reference model feeds expected pulses and status per cycle.
`timescale 1ns/1ps
module tb_mcu_spi_phy;
  localparam int SYNC   = 2;
  localparam int TO_CYC = 16;

  logic       SClk = 1'b0;
  logic       nReset = 1'b0, MCUReady = 1'b1, nMCUSel = 1'b1;
  logic       SPIClkRunning = 1'b0, SPIClkStretch = 1'b0, ClearStatus = 1'b0;
  logic       SPIClk, MCUReadyFallingEdge, FrameError, Timeout;
  logic [7:0] ByteCount;

  mcu_spi_phy #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO_CYC), .TIMEOUT_W(5)) dut (
    .SClk               (SClk),
    .nReset             (nReset),
    .MCUReady           (MCUReady),
    .nMCUSel            (nMCUSel),
    .SPIClkRunning      (SPIClkRunning),
    .SPIClkStretch      (SPIClkStretch),
    .ClearStatus        (ClearStatus),
    .SPIClk             (SPIClk),
    .MCUReadyFallingEdge(MCUReadyFallingEdge),
    .ByteCount          (ByteCount),
    .FrameError         (FrameError),
    .Timeout            (Timeout)
  );

  always #5 SClk = ~SClk;

  typedef struct {
    int cyc;
    int bytes;
    int fe;
    int to;
    int pulses;
  } stat_t;

  stat_t stat_q[$];
  int    pulse_q[$];
  int    cyc = 0, tests = 0, fails = 0, spi_cnt = 0;

  // Reference model: total bits shifted in the frame, SPI clock pulses, sticky flags.
  int m_bits = 0, m_pulses = 0, m_fe = 0, m_to = 0, m_run = 0, m_to_at = -1;
  int p_nsel = 1, p_str = 0, p_rdy = 1;

  always @(posedge SClk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Drives one SClk cycle of master controls and records the expected outcome.
  task automatic step(int nsel, int run, int str, int rdy, int clr);
    int shifting, misaligned;
    stat_t s;
    nMCUSel       = (nsel != 0);
    SPIClkRunning = (run != 0);
    SPIClkStretch = (str != 0);
    MCUReady      = (rdy != 0);
    ClearStatus   = (clr != 0);
    shifting   = (run != 0 && str == 0 && nsel == 0) ? 1 : 0;
    misaligned = (m_bits % 8 != 0) ? 1 : 0;
    if (p_rdy != 0 && rdy == 0) pulse_q.push_back(cyc + SYNC + 1);
    if (((p_nsel == 0 && nsel != 0) || (p_str == 0 && str != 0)) && misaligned != 0) m_fe = 1;
    else if (clr != 0) m_fe = 0;
    if (p_nsel != 0 && nsel == 0) m_bits = 0;
    else if (shifting != 0) m_bits++;
    m_pulses += shifting;
`ifdef MCU_SPI_STRETCH_WATCHDOG_EN
    if (nsel == 0 && str != 0) m_run++;
    else m_run = 0;
    if (m_run == TO_CYC) begin
      pulse_q.push_back(cyc + 2);
      m_to_at = cyc + 2;
    end
`endif
    if (clr != 0) m_to = 0;
    p_nsel = nsel; p_str = str; p_rdy = rdy;
    @(posedge SClk);
    #1;
    if (m_to_at == cyc) m_to = 1;
    s.cyc    = cyc;
    s.bytes  = (m_bits / 8 > 255) ? 255 : m_bits / 8;
    s.fe     = m_fe;
    s.to     = m_to;
    s.pulses = m_pulses;
    stat_q.push_back(s);
  endtask

  task automatic frame(int nbits, int st_at, int clr_end);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < nbits; i++) begin
      if (i == st_at) begin
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        repeat ($urandom_range(1, 3)) step(0, 1, 1, 1, 0);
      end
      step(0, 1, 0, 1, 0);
    end
    step(1, 0, 0, 1, clr_end);
    step(1, 0, 0, 1, 0);
  endtask

  // Monitor: registered outputs checked mid-high phase, SPIClk pulses counted mid-low phase.
  initial begin
    stat_t s;
    forever begin
      @(posedge SClk);
      #3;
      if (nReset) begin
        while (pulse_q.size() > 0 && pulse_q[0] < cyc) begin
          tests++; fails++;
          $display("FAIL ready_pulse missing: got no pulse, expected at cycle %0d", pulse_q.pop_front());
        end
        if (MCUReadyFallingEdge) begin
          tests++;
          if (pulse_q.size() == 0 || pulse_q[0] != cyc) begin
            fails++;
            $display("FAIL ready_pulse unexpected: got pulse at cycle %0d, expected next at %0d",
                     cyc, (pulse_q.size() == 0) ? -1 : pulse_q[0]);
          end else void'(pulse_q.pop_front());
        end
        chk("spiclk_high_phase", int'(SPIClk), 0);
        while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
          s = stat_q.pop_front();
          chk("byte_count", int'(ByteCount), s.bytes);
          chk("frame_error", int'(FrameError), s.fe);
          chk("timeout", int'(Timeout), s.to);
          chk("spiclk_pulses", spi_cnt, s.pulses);
        end
      end
      #4;
      if (nReset && SPIClk === 1'b1) spi_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench still running, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nb, sa, ce;
    repeat (3) @(posedge SClk);
    #1 nReset = 1'b1;
    repeat (6) step(1, 0, 0, 1, 0);

    frame(16, -1, 0);          // two clean bytes
    frame(16, 8, 0);           // stretch at a byte boundary with MCU ack
    frame(5, -1, 0);           // aborted mid-byte
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0);
    frame(8, -1, 0);

    // Long stretch with no ack
    step(0, 0, 0, 1, 0);
    repeat (8) step(0, 1, 0, 1, 0);
    repeat (20) step(0, 1, 1, 1, 0);
    repeat (8) step(0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0);

    // Ack edges while deselected still pulse
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);

    repeat (40) begin
      nb = int'($urandom_range(1, 24));
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      ce = int'($urandom_range(0, 1));
      frame(nb, sa, ce);
      if ($urandom_range(0, 3) == 0) begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
      end
      step(1, 0, 0, 1, int'($urandom_range(0, 1)));
      step(1, 0, 0, 1, 0);
    end

    frame(2064, -1, 0);        // ByteCount saturation

    // Reset in the low half of SClk while the SPI clock is high
    step(0, 0, 0, 1, 0);
    repeat (11) step(0, 1, 0, 1, 0);
    m_pulses++;
    #7;
    chk("spiclk_before_reset", int'(SPIClk), 1);
    nReset = 1'b0;
    #1;
    chk("reset_spiclk", int'(SPIClk), 0);
    chk("reset_byte_count", int'(ByteCount), 0);
    chk("reset_frame_error", int'(FrameError), 0);
    chk("reset_timeout", int'(Timeout), 0);
    chk("reset_ready_pulse", int'(MCUReadyFallingEdge), 0);
    nMCUSel = 1'b1; SPIClkRunning = 1'b0; SPIClkStretch = 1'b0; ClearStatus = 1'b0; MCUReady = 1'b1;
    m_bits = 0; m_fe = 0; m_to = 0; m_run = 0; m_to_at = -1;
    p_nsel = 1; p_str = 0; p_rdy = 1;
    @(posedge SClk);
    #1 nReset = 1'b1;
    repeat (4) step(1, 0, 0, 1, 0);
    frame(9, -1, 0);
    repeat (6) step(1, 0, 0, 1, 0);
    repeat (4) @(posedge SClk);

    chk("pulses_outstanding", pulse_q.size(), 0);
    chk("status_outstanding", stat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
